// File: rtl/rxuart_fifo.sv
// UART receiver with configurable frame format, show-ahead FIFO and
// sticky error flags.
module rxuart_fifo #(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int BAUDRATE   = 921_600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          err_clr
);

  localparam int DIV = (CLK_FREQ + BAUDRATE / 2) / BAUDRATE;
  localparam int TW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  localparam logic [TW-1:0] T_HALF = TW'(DIV / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, BRK
  } state_t;

  state_t               state, state_d;
  logic                 rx_meta, rxs;
  logic [TW-1:0]        timer;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 done;
  logic                 fire, last_stop;
  logic                 fe_set, frame_end;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]        count;
  logic                 par_ok, good, pe_set;
  logic                 push, pop, ov_set;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign fire      = (timer == '0);
  assign last_stop = (STOP_BITS == 1) || stop_idx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (!rxs) state_d = START;
      START: if (fire) state_d = rxs ? IDLE : DATA;
      DATA:
        if (fire && bit_idx == B_LAST)
          state_d = (PARITY != 0) ? PAR : STOP;
      PAR:   if (fire) state_d = STOP;
      STOP:
        if (fire) begin
          if (!rxs)           state_d = BRK;
          else if (last_stop) state_d = IDLE;
        end
      BRK:   if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fe_set    = 1'b0;
    frame_end = 1'b0;
    if (state == STOP && fire) begin
      fe_set    = !rxs;
      frame_end = rxs && last_stop;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= frame_end;
      if (state == IDLE)     timer <= rxs ? '0 : T_HALF;
      else if (state == BRK) timer <= '0;
      else if (fire)         timer <= T_FULL;
      else                   timer <= timer - 1'b1;
      if (state == START)
        bit_idx <= '0;
      else if (state == DATA && fire)
        bit_idx <= bit_idx + 1'b1;
      if (state == DATA && fire)
        shreg <= {rxs, shreg[DATA_BITS-1:1]};
      if (state == PAR && fire)
        par_bit <= rxs;
      if (state != STOP) stop_idx <= 1'b0;
      else if (fire)     stop_idx <= 1'b1;
    end
  end

  // odd parity expects the inverse of the data XOR
  assign par_ok = (PARITY == 0) ||
                  (par_bit == ((PARITY == 1) ? ~^shreg : ^shreg));
  assign good   = done && par_ok;
  assign pe_set = done && !par_ok;

  assign rx_valid = (count != '0);
  assign rx_count = count;
  assign pop      = rx_valid && rx_ready;
  assign push     = good && (count != C_FULL || pop);
  assign ov_set   = good && !push;
  assign rd_next  = pop ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rx_data <= '0;
    end else begin
      rd_ptr <= rd_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      // head bypass covers a push into an empty (or emptying) queue
      if (push || pop)
        rx_data <= (push && wr_ptr == rd_next) ? shreg : mem[rd_next];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (fe_set)       frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (pe_set)       parity_err <= 1'b1;
      else if (err_clr) parity_err <= 1'b0;
      if (ov_set)       overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rxuart_fifo.sv
// Bench for rxuart_fifo: an 8N1/16-deep receiver and an 8E2/4-deep
// receiver against a queue-based frame model.
module tb_rxuart_fifo;

  localparam int DIV = 13;

  logic       clk = 1'b0;
  logic       resetn, err_clr;
  logic       rx_a, ready_a, valid_a, fe_a, pe_a, ov_a;
  logic       rx_b, ready_b, valid_b, fe_b, pe_b, ov_b;
  logic [7:0] data_a, data_b;
  logic [4:0] cnt_a;
  logic [2:0] cnt_b;

  int         checks = 0;
  int         failures = 0;
  int         vcnt_a = 0;
  bit         rnd = 1'b0;
  bit         exp_fe [2];
  bit         exp_pe [2];
  bit         exp_ov [2];
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];

  always #5 clk = ~clk;

  rxuart_fifo u_a (
    .clk(clk), .resetn(resetn), .rx(rx_a),
    .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
    .rx_count(cnt_a), .frame_err(fe_a), .parity_err(pe_a),
    .overrun(ov_a), .err_clr(err_clr)
  );

  rxuart_fifo #(.PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .resetn(resetn), .rx(rx_b),
    .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b),
    .rx_count(cnt_b), .frame_err(fe_b), .parity_err(pe_b),
    .overrun(ov_b), .err_clr(err_clr)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (valid_a) vcnt_a++;
      if (valid_a && ready_a) begin
        if (q_a.size() == 0) check("pop_a_unexp", 1, 0);
        else check("data_a", int'(data_a), int'(q_a.pop_front()));
      end
      if (valid_b && ready_b) begin
        if (q_b.size() == 0) check("pop_b_unexp", 1, 0);
        else check("data_b", int'(data_b), int'(q_b.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd) begin
        ready_a = 1'($urandom % 2);
        ready_b = 1'($urandom % 2);
      end
    end
  endtask

  task automatic setrx(input int d, input logic v);
    if (d == 0) rx_a = v;
    else        rx_b = v;
  endtask

  task automatic model_push(input int d, input logic [7:0] v);
    if (d == 0) begin
      if (q_a.size() < 16) q_a.push_back(v);
      else exp_ov[0] = 1'b1;
    end else begin
      if (q_b.size() < 4) q_b.push_back(v);
      else exp_ov[1] = 1'b1;
    end
  endtask

  // d=0: 8N1 receiver, d=1: 8E2 receiver
  task automatic send(input int d, input logic [7:0] v,
                      input bit bad, input bit stop_low);
    setrx(d, 1'b0);
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      setrx(d, v[i]);
      tick(DIV);
    end
    if (d == 1) begin
      setrx(d, (^v) ^ bad);
      tick(DIV);
      if (bad) exp_pe[1] = 1'b1;
    end
    if (stop_low) begin
      exp_fe[d] = 1'b1;
      setrx(d, 1'b0);
      tick(3 * DIV);
    end else begin
      if (!(d == 1 && bad)) model_push(d, v);
      setrx(d, 1'b1);
      tick(d == 0 ? DIV : 2 * DIV);
    end
    setrx(d, 1'b1);
    tick(2);
  endtask

  task automatic check_flags();
    check("fe_a", int'(fe_a), int'(exp_fe[0]));
    check("pe_a", int'(pe_a), int'(exp_pe[0]));
    check("ov_a", int'(ov_a), int'(exp_ov[0]));
    check("fe_b", int'(fe_b), int'(exp_fe[1]));
    check("pe_b", int'(pe_b), int'(exp_pe[1]));
    check("ov_b", int'(ov_b), int'(exp_ov[1]));
  endtask

  task automatic clear_flags();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    for (int i = 0; i < 2; i++) begin
      exp_fe[i] = 1'b0;
      exp_pe[i] = 1'b0;
      exp_ov[i] = 1'b0;
    end
  endtask

  initial begin
    resetn = 1'b0; err_clr = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1;
    ready_a = 1'b0; ready_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_fe[i] = 1'b0; exp_pe[i] = 1'b0; exp_ov[i] = 1'b0;
    end
    tick(3);
    check("rst_valid_a", int'(valid_a), 0);
    check("rst_cnt_a", int'(cnt_a), 0);
    check("rst_data_a", int'(data_a), 0);
    check("rst_valid_b", int'(valid_b), 0);
    check("rst_cnt_b", int'(cnt_b), 0);
    check_flags();
    resetn = 1'b1;
    tick(3);

    // single byte, consumer always ready
    ready_a = 1'b1;
    vcnt_a = 0;
    send(0, 8'hA5, 1'b0, 1'b0);
    tick(5);
    check("a5_valid_cycles", vcnt_a, 1);
    check("a5_drained", q_a.size(), 0);
    check_flags();

    // parity error, clear, then good parity
    ready_b = 1'b1;
    send(1, 8'h03, 1'b1, 1'b0);
    tick(2);
    check_flags();
    check("par_cnt_b", int'(cnt_b), 0);
    clear_flags();
    check_flags();
    send(1, 8'h03, 1'b0, 1'b0);
    tick(5);
    check("par_good_drained", q_b.size(), 0);
    check_flags();

    // overrun on a 4-deep queue
    ready_b = 1'b0;
    for (int i = 1; i <= 5; i++) send(1, 8'(i * 8'h11), 1'b0, 1'b0);
    tick(2);
    check("ovr_cnt_b", int'(cnt_b), 4);
    check_flags();
    clear_flags();
    ready_b = 1'b1;
    tick(10);
    check("ovr_valid_b", int'(valid_b), 0);
    check("ovr_drained", q_b.size(), 0);

    // false start
    rx_a = 1'b0;
    tick(3);
    rx_a = 1'b1;
    tick(2 * DIV);
    check("glitch_valid", int'(valid_a), 0);
    check_flags();
    send(0, 8'h5A, 1'b0, 1'b0);
    tick(5);
    check("glitch_drained", q_a.size(), 0);

    // stop bit held low, then recovery
    send(0, 8'h99, 1'b0, 1'b1);
    check_flags();
    check("brk_cnt_a", int'(cnt_a), 0);
    clear_flags();
    send(0, 8'hC3, 1'b0, 1'b0);
    tick(5);
    check("brk_drained", q_a.size(), 0);
    check_flags();

    // reset mid-frame with two entries queued
    ready_a = 1'b0;
    send(0, 8'h01, 1'b0, 1'b0);
    send(0, 8'h02, 1'b0, 1'b0);
    check("pre_rst_cnt", int'(cnt_a), 2);
    rx_a = 1'b0;
    tick(DIV);
    for (int i = 0; i < 3; i++) begin
      rx_a = 1'b1;
      tick(DIV);
    end
    resetn = 1'b0;
    #1;
    check("mid_rst_valid", int'(valid_a), 0);
    check("mid_rst_cnt", int'(cnt_a), 0);
    check("mid_rst_data", int'(data_a), 0);
    q_a.delete();
    q_b.delete();
    rx_a = 1'b1;
    tick(3);
    resetn = 1'b1;
    tick(5);
    ready_a = 1'b1;
    send(0, 8'h7E, 1'b0, 1'b0);
    tick(5);
    check("post_rst_drained", q_a.size(), 0);
    check_flags();

    // randomized traffic with random consumer stalls
    rnd = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int         d;
      logic [7:0] v;
      bit         bad;
      d   = int'($urandom % 2);
      v   = 8'($urandom);
      bad = (d == 1) && ($urandom % 4 == 0);
      send(d, v, bad, 1'b0);
      tick(1 + int'($urandom % 5));
      check_flags();
      if (bad) clear_flags();
    end
    rnd = 1'b0;
    ready_a = 1'b1;
    ready_b = 1'b1;
    tick(20);
    check("rnd_drained_a", q_a.size(), 0);
    check("rnd_drained_b", q_b.size(), 0);
    check("rnd_valid_a", int'(valid_a), 0);
    check("rnd_valid_b", int'(valid_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
